// File: rtl/smf_c2c_pkg.sv
// Shared constants for the C2C slave register block: register offsets,
// AXI response codes and FSM state encodings.
package smf_c2c_pkg;

    localparam logic [7:0] REG_ID      = 8'h00;
    localparam logic [7:0] REG_SCRATCH = 8'h04;
    localparam logic [7:0] REG_LED     = 8'h08;
    localparam logic [7:0] REG_LINK    = 8'h0C;
    localparam logic [7:0] REG_DROP    = 8'h10;
    localparam logic [7:0] REG_HB      = 8'h14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

endpackage

// File: rtl/c2c_sync_2ff.sv
// Parameterised-width two-flop synchroniser for asynchronous status inputs.
module c2c_sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/smf_c2c_slave_regs.sv
// AXI4-Lite register slave on the far end of the Aurora C2C link: ID, scratch,
// LEDs, link status, link-drop counter and heartbeat.
module smf_c2c_slave_regs
    import smf_c2c_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] ID_VALUE  = 32'h534D_4601,
    parameter logic [3:0]  LED_RESET = 4'h0
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic              channel_up,
    input  logic [1:0]        lane_up,
    output logic [3:0]        led_out
);

    localparam int IW = ADDR_W - 2;
    localparam logic [IW-1:0] IDX_ID      = IW'(REG_ID >> 2);
    localparam logic [IW-1:0] IDX_SCRATCH = IW'(REG_SCRATCH >> 2);
    localparam logic [IW-1:0] IDX_LED     = IW'(REG_LED >> 2);
    localparam logic [IW-1:0] IDX_LINK    = IW'(REG_LINK >> 2);
    localparam logic [IW-1:0] IDX_DROP    = IW'(REG_DROP >> 2);
    localparam logic [IW-1:0] IDX_HB      = IW'(REG_HB >> 2);

    wire clk   = s_axi_aclk;
    wire rst_n = s_axi_aresetn;

    // ---------------- link status synchronisation ----------------
    logic [2:0] link_s;
    logic       ch_d;
    logic       drop;

    c2c_sync_2ff #(.W(3)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({lane_up, channel_up}),
        .q     (link_s)
    );

    assign drop = ch_d & ~link_s[0];

    // ---------------- registers ----------------
    logic [31:0] scratch;
    logic [3:0]  led;
    logic [15:0] drop_cnt;
    logic [31:0] hb;

    // ---------------- write channel ----------------
    wstate_t         w_state, w_next;
    logic            aw_held, w_held;
    logic [IW-1:0]   awaddr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic            do_write;
    logic            aw_hs, w_hs;
    logic [IW-1:0]   wa_idx;
    logic [31:0]     wd;
    logic [3:0]      ws;
    logic            wa_mapped;

    always_ff @(posedge clk) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        do_write      = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = ~aw_held;
                s_axi_wready  = ~w_held;
                if ((aw_held | s_axi_awvalid) && (w_held | s_axi_wvalid)) begin
                    do_write = 1'b1;
                    w_next   = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bvalid && s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid & s_axi_wready;
    // The write may complete using a held beat or one handshaking this cycle.
    assign wa_idx = aw_held ? awaddr_q : s_axi_awaddr[ADDR_W-1:2];
    assign wd     = w_held ? wdata_q : s_axi_wdata;
    assign ws     = w_held ? wstrb_q : s_axi_wstrb;
    assign wa_mapped = (wa_idx == IDX_ID) || (wa_idx == IDX_SCRATCH) || (wa_idx == IDX_LED) ||
                       (wa_idx == IDX_LINK) || (wa_idx == IDX_DROP) || (wa_idx == IDX_HB);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else begin
            if (s_axi_bvalid && s_axi_bready) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    awaddr_q <= s_axi_awaddr[ADDR_W-1:2];
                end
                if (w_hs) begin
                    w_held  <= 1'b1;
                    wdata_q <= s_axi_wdata;
                    wstrb_q <= s_axi_wstrb;
                end
                if (do_write) begin
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= wa_mapped ? RESP_OKAY : RESP_SLVERR;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scratch  <= '0;
            led      <= LED_RESET;
            drop_cnt <= '0;
            hb       <= '0;
            ch_d     <= 1'b0;
        end else begin
            hb   <= hb + 32'd1;
            ch_d <= link_s[0];
            if (do_write && wa_idx == IDX_SCRATCH) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) scratch[8*b +: 8] <= wd[8*b +: 8];
            end
            if (do_write && wa_idx == IDX_LED && ws[0]) led <= wd[3:0];
            // A clear that lands on a drop keeps that drop.
            if (do_write && wa_idx == IDX_DROP)
                drop_cnt <= drop ? 16'd1 : 16'd0;
            else if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign led_out = led;

    // ---------------- read channel ----------------
    rstate_t       r_state, r_next;
    logic          ar_hs;
    logic [IW-1:0] ra_idx;
    logic [31:0]   rd_mux;
    logic [1:0]    rd_resp;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) r_next = R_RESP;
            end
            R_RESP: begin
                if (s_axi_rvalid && s_axi_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign ra_idx = s_axi_araddr[ADDR_W-1:2];

    always_comb begin
        rd_mux  = '0;
        rd_resp = RESP_OKAY;
        case (ra_idx)
            IDX_ID:      rd_mux = ID_VALUE;
            IDX_SCRATCH: rd_mux = scratch;
            IDX_LED:     rd_mux = {28'd0, led};
            IDX_LINK:    rd_mux = {29'd0, link_s};
            IDX_DROP:    rd_mux = {16'd0, drop_cnt};
            IDX_HB:      rd_mux = hb;
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_mux;
            s_axi_rresp  <= rd_resp;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_smf_c2c_slave_regs.sv
// Directed bench for smf_c2c_slave_regs with hand-computed expectations.
module tb_smf_c2c_slave_regs;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [11:0] awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        channel_up;
    logic [1:0]  lane_up;
    logic [3:0]  led_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    smf_c2c_slave_regs dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (aresetn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .channel_up    (channel_up),
        .lane_up       (lane_up),
        .led_out       (led_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
        int  t = 0;
        bit  aw_go, w_go;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        while (awvalid || wvalid) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            tick(1);
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            if (++t > 50) begin
                chk("wr_addr_timeout", 32'd1, 32'd0);
                awvalid = 1'b0; wvalid = 1'b0;
            end
        end
        t = 0;
        while (!bvalid && t < 50) begin tick(1); t++; end
        if (!bvalid) chk("wr_b_timeout", 32'd0, 32'd1);
        resp = bresp;
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t = 0;
        bit go;
        araddr = a; arvalid = 1'b1;
        while (arvalid) begin
            go = arready;
            tick(1);
            if (go) arvalid = 1'b0;
            if (++t > 50) begin chk("rd_addr_timeout", 32'd1, 32'd0); arvalid = 1'b0; end
        end
        t = 0;
        while (!rvalid && t < 50) begin tick(1); t++; end
        if (!rvalid) chk("rd_r_timeout", 32'd0, 32'd1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
    endtask

    logic [31:0] d, v1, v2;
    logic [1:0]  r;

    initial begin
        aresetn = 1'b0; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 0; rready = 0; wdata = '0; wstrb = '0; channel_up = 0; lane_up = '0;
        tick(3);
        aresetn = 1'b1;

        // reset state
        chk("rst_awready", awready, 1);
        chk("rst_wready",  wready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_bvalid",  bvalid, 0);
        chk("rst_rvalid",  rvalid, 0);
        chk("rst_led",     led_out, 4'h0);
        axi_rd(12'h000, d, r);
        chk("id_data", d, 32'h534D4601); chk("id_resp", r, 2'b00);
        axi_rd(12'h008, d, r);
        chk("led_rst_rd", d, 0);

        // byte strobes
        axi_wr(12'h004, 32'hDEADBEEF, 4'b0101, r);
        chk("scr_wr_resp", r, 2'b00);
        axi_rd(12'h004, d, r);
        chk("scr_strb", d, 32'h00AD00EF);

        // W leads AW by 3 cycles
        wdata = 32'h0000000A; wstrb = 4'hF; wvalid = 1'b1;
        tick(1);
        wvalid = 1'b0;
        chk("w_first_wready", wready, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("w_first_no_b", bvalid, 0);
        end
        awaddr = 12'h008; awvalid = 1'b1;
        tick(1);
        awvalid = 1'b0;
        chk("w_first_b_lat", bvalid, 1);
        chk("w_first_led", led_out, 4'hA);
        // backpressure on B
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("bp_bvalid", bvalid, 1);
            chk("bp_awready", awready, 0);
            chk("bp_wready", wready, 0);
            chk("bp_bresp", bresp, 2'b00);
        end
        bready = 1'b1; tick(1); bready = 1'b0;
        chk("b_done", bvalid, 0);

        // LED honours only wstrb[0]; upper bits read 0
        axi_wr(12'h008, 32'hFFFFFFF5, 4'b1110, r);
        chk("led_strb_hold", led_out, 4'hA);
        axi_wr(12'h008, 32'hFFFFFFF5, 4'b0001, r);
        axi_rd(12'h008, d, r);
        chk("led_rd", d, 32'h5);

        // link status and drops
        channel_up = 1'b1; lane_up = 2'b10;
        tick(4);
        axi_rd(12'h00C, d, r);
        chk("link_status", d, 32'h5);
        for (int i = 0; i < 3; i++) begin
            channel_up = 1'b0; tick(4);
            channel_up = 1'b1; tick(4);
        end
        axi_rd(12'h010, d, r);
        chk("drop_cnt3", d, 3);

        // clear landing on the synchronised drop
        channel_up = 1'b0;
        tick(2);
        awaddr = 12'h010; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("clr_drop_b", bvalid, 1);
        bready = 1'b1; tick(1); bready = 1'b0;
        channel_up = 1'b1; tick(4);
        axi_rd(12'h010, d, r);
        chk("clr_with_drop", d, 1);

        // unmapped and RO
        axi_rd(12'h040, d, r);
        chk("unmap_rd_data", d, 0); chk("unmap_rd_resp", r, 2'b10);
        axi_wr(12'h050, 32'h12345678, 4'hF, r);
        chk("unmap_wr_resp", r, 2'b10);
        axi_wr(12'h000, 32'h12345678, 4'hF, r);
        chk("ro_wr_resp", r, 2'b00);
        axi_rd(12'h000, d, r);
        chk("id_unchanged", d, 32'h534D4601);

        // simultaneous read and write to scratch: read sees old value
        axi_wr(12'h004, 32'h11111111, 4'hF, r);
        awaddr = 12'h004; wdata = 32'h22222222; wstrb = 4'hF; araddr = 12'h004;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("rw_same_old", rdata, 32'h11111111);
        bready = 1'b1; rready = 1'b1; tick(1); bready = 1'b0; rready = 1'b0;
        axi_rd(12'h004, d, r);
        chk("rw_same_new", d, 32'h22222222);

        // heartbeat: ar handshakes 10 cycles apart
        araddr = 12'h014; arvalid = 1'b1;
        tick(1);
        arvalid = 1'b0; v1 = rdata; rready = 1'b1;
        tick(1);
        rready = 1'b0;
        tick(8);
        arvalid = 1'b1;
        tick(1);
        arvalid = 1'b0; v2 = rdata; rready = 1'b1;
        tick(1);
        rready = 1'b0;
        chk("hb_delta", v2 - v1, 10);

        // reset while in W_RESP
        awaddr = 12'h004; wdata = 32'h33333333; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("pre_rst_bvalid", bvalid, 1);
        aresetn = 1'b0;
        tick(1);
        aresetn = 1'b1;
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_awready", awready, 1);
        chk("mid_rst_wready", wready, 1);
        chk("mid_rst_led", led_out, 4'h0);
        axi_rd(12'h004, d, r);
        chk("mid_rst_scratch", d, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
